// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accepts commands over valid/ready, drives a registered
// 2-bit-op ALU with a one-cycle enable pulse, captures the result one cycle
// later and returns it over a valid/ready response channel. Optional chaining
// replaces operand A with the previously captured result.
module alu_cmd_issuer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] last_res;
  logic             have_last;
  logic             accept;
  logic             rsp_fire;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_fire  = (state == RESP) & rsp_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode: fixed four-cycle walk, RESP waits on rsp_ready
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive: operands latched at accept and held until the next accept;
  // alu_en is set on the accept edge so it is high exactly during ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      alu_en <= 1'b0;
    end else begin
      alu_en <= accept;
      if (accept) begin
        alu_op <= cmd_op;
        alu_b  <= cmd_b;
        alu_a  <= (cmd_chain && have_last) ? last_res : cmd_a;
      end
    end
  end

  // Response path: capture in CAPT, present in RESP, count handshakes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_valid <= 1'b0;
      last_res  <= '0;
      have_last <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (state == CAPT) begin
        rsp_data  <= alu_result;
        last_res  <= alu_result;
        rsp_op    <= alu_op;
        have_last <= 1'b1;
        rsp_valid <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        done_cnt  <= done_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural registered ALU.
module tb_alu_cmd_issuer;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_a;
  logic [W-1:0]  cmd_b;
  logic          cmd_chain;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [1:0]    alu_op;
  logic          alu_en;
  logic [W-1:0]  alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [1:0]    rsp_op;
  logic [CW-1:0] done_cnt;

  alu_cmd_issuer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU (unreset, as in the real part)
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_op)
        2'd0: alu_result <= alu_a + alu_b;
        2'd1: alu_result <= alu_a - alu_b;
        2'd2: alu_result <= alu_a & alu_b;
        default: alu_result <= alu_a | alu_b;
      endcase
    end
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   op;
  } rsp_t;

  rsp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit            pend_cnt = 0;
  int            en_pulses = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake, then checks
  // the counter one cycle later
  rsp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_en) en_pulses++;
      if (pend_cnt) begin
        chk("done_cnt", W'(done_cnt), W'(exp_cnt));
        pend_cnt = 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got data %0h, expected no response", rsp_data);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_op", W'(rsp_op), W'(mon_e.op));
        end
        exp_cnt  = exp_cnt + 1'b1;
        pend_cnt = 1;
      end
    end
  end

  // One command from accept to response handshake; hold>0 applies backpressure
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input bit chain, input logic [W-1:0] exp_a,
                       input logic [W-1:0] exp_data, input int hold);
    rsp_t e;
    int cyc;
    logic [W-1:0] snap;
    @(negedge clk);
    chk("cmd_ready_idle", W'(cmd_ready), 1);
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain;
    rsp_ready = (hold == 0);
    @(posedge clk);
    e.data = exp_data; e.op = op;
    sb.push_back(e);
    #1;
    cmd_valid = 0; cmd_a = '1; cmd_b = '1; cmd_op = ~op; cmd_chain = 0;
    chk("alu_en_issue", W'(alu_en), 1);
    chk("alu_a", alu_a, exp_a);
    chk("alu_b", alu_b, b);
    chk("alu_op", W'(alu_op), W'(op));
    chk("cmd_ready_busy", W'(cmd_ready), 0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("alu_en_single", W'(alu_en), 0);
    end while (!rsp_valid && cyc < 10);
    chk("rsp_latency", W'(cyc), 2);
    if (!rsp_valid) return;
    if (hold > 0) begin
      snap = rsp_data;
      cmd_valid = 1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("bp_rsp_valid", W'(rsp_valid), 1);
        chk("bp_rsp_data", rsp_data, snap);
        chk("bp_cmd_ready", W'(cmd_ready), 0);
        chk("bp_alu_b", alu_b, b);
        chk("bp_done_cnt", W'(done_cnt), W'(exp_cnt));
      end
      cmd_valid = 0;
      rsp_ready = 1;
    end
    @(posedge clk); #1;
    chk("rsp_valid_drop", W'(rsp_valid), 0);
    chk("cmd_ready_back", W'(cmd_ready), 1);
  endtask

  task automatic apply_reset();
    reset = 1;
    sb.delete();
    exp_cnt = '0;
    pend_cnt = 0;
    #1;
    chk("rst_rsp_valid", W'(rsp_valid), 0);
    chk("rst_alu_en", W'(alu_en), 0);
    chk("rst_done_cnt", W'(done_cnt), 0);
    chk("rst_cmd_ready", W'(cmd_ready), 1);
    chk("rst_alu_a", alu_a, 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int base;
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_chain = 0; rsp_ready = 1;
    repeat (2) @(negedge clk);
    chk("init_rsp_data", rsp_data, 0);
    chk("init_rsp_op", W'(rsp_op), 0);
    reset = 0;

    // Chain right after reset falls back to cmd_a
    do_op(7, 1, 0, 1, 7, 8, 0);
    do_op(5, 3, 0, 0, 5, 8, 0);
    // Wrap-around sub and add
    do_op(0, 1, 1, 0, 0, 32'hFFFF_FFFF, 0);
    do_op(32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    // Chaining
    do_op(10, 6, 2, 0, 10, 2, 0);
    do_op(99, 1, 3, 1, 2, 3, 0);
    // Backpressure
    do_op(100, 23, 0, 0, 100, 123, 5);

    // Reset while in CAPT: command abandoned
    @(negedge clk);
    cmd_valid = 1; cmd_a = 1; cmd_b = 1; cmd_op = 0; cmd_chain = 0;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    apply_reset();
    do_op(20, 4, 1, 1, 20, 16, 0);

    // Counter wrap over five back-to-back ops
    @(negedge clk);
    apply_reset();
    base = en_pulses;
    do_op(1, 2, 0, 0, 1, 3, 0);
    do_op(7, 3, 1, 0, 7, 4, 0);
    do_op(12, 10, 2, 0, 12, 8, 0);
    do_op(12, 3, 3, 0, 12, 15, 0);
    do_op(0, 1, 0, 1, 15, 16, 0);
    repeat (3) @(negedge clk);
    chk("alu_en_pulses", W'(en_pulses - base), 5);
    chk("sb_empty", W'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
